// File: rtl/rio_frame_sequencer.sv
// Frame sequencer for the rio SPI command path: header check, atomic payload commit,
// link watchdog and the FAULT/ARMING/RUN/ESTOP state machine.
module rio_frame_sequencer #(
    parameter int          BUFFER_SIZE = 272,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          CLK_FREQ    = 100000000,
    parameter int          TIMEOUT_MS  = 100,
    parameter int          ARM_FRAMES  = 3
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    frame_valid,
    input  logic [BUFFER_SIZE-1:0]  rx_data,
    input  logic                    estop_req,
    output logic [BUFFER_SIZE-33:0] cmd_data,
    output logic                    cmd_update,
    output logic [31:0]             header_tx,
    output logic                    pkg_timeout,
    output logic                    fault,
    output logic [1:0]              state,
    output logic [15:0]             bad_frame_cnt
);

    localparam int          TO_CYC    = CLK_FREQ / 1000 * TIMEOUT_MS;
    localparam int          WW        = $clog2(TO_CYC + 1);
    localparam int          GW        = $clog2(ARM_FRAMES + 1);
    localparam int          PW        = BUFFER_SIZE - 32;
    localparam logic [WW-1:0] TO_VAL  = WW'(TO_CYC);
    localparam logic [31:0] HDR_ESTOP = 32'h65737470;
    localparam logic [31:0] HDR_DATA  = 32'h64617461;

    typedef enum logic [1:0] {
        S_FAULT  = 2'd0,
        S_ARMING = 2'd1,
        S_RUN    = 2'd2,
        S_ESTOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   cmd_data_q, cmd_data_d;
    logic            cmd_update_q, cmd_update_d;
    logic [31:0]     header_tx_q, header_tx_d;
    logic            pkg_timeout_q, pkg_timeout_d;
    logic            fault_q, fault_d;
    logic [15:0]     bad_cnt_q, bad_cnt_d;
    logic [WW-1:0]   wdog_q, wdog_d, wdog_inc;
    logic [GW-1:0]   good_cnt_q, good_cnt_d;

    logic [31:0]     hdr;
    logic            good, bad, expire;

    always_comb begin
        // Header arrives little-endian on the wire; swap bytes before matching.
        hdr      = {rx_data[BUFFER_SIZE-25 -: 8], rx_data[BUFFER_SIZE-17 -: 8],
                    rx_data[BUFFER_SIZE-9 -: 8],  rx_data[BUFFER_SIZE-1 -: 8]};
        good     = frame_valid && (hdr == MSGID);
        bad      = frame_valid && (hdr != MSGID);
        wdog_inc = (wdog_q == TO_VAL) ? TO_VAL : wdog_q + 1'b1;
        // A good frame on the expiry cycle reloads the watchdog and suppresses the timeout.
        expire   = !good && (wdog_inc == TO_VAL);

        state_d      = state_q;
        cmd_data_d   = cmd_data_q;
        cmd_update_d = 1'b0;
        good_cnt_d   = good_cnt_q;
        wdog_d       = good ? '0 : wdog_inc;
        bad_cnt_d    = (bad && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;

        if (estop_req) begin
            state_d    = S_ESTOP;
            cmd_data_d = '0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (good) begin
                        cmd_data_d   = rx_data[PW-1:0];
                        cmd_update_d = 1'b1;
                    end else if (expire) begin
                        state_d    = S_FAULT;
                        cmd_data_d = '0;
                    end
                end
                S_ARMING: begin
                    if (good) begin
                        if (int'(good_cnt_q) + 1 >= ARM_FRAMES) begin
                            state_d      = S_RUN;
                            cmd_data_d   = rx_data[PW-1:0];
                            cmd_update_d = 1'b1;
                            good_cnt_d   = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else if (bad || expire) begin
                        state_d    = S_FAULT;
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    // FAULT and ESTOP (with the request released) leave on the first good frame.
                    if (good) begin
                        if (ARM_FRAMES <= 1) begin
                            state_d      = S_RUN;
                            cmd_data_d   = rx_data[PW-1:0];
                            cmd_update_d = 1'b1;
                            good_cnt_d   = '0;
                        end else begin
                            state_d    = S_ARMING;
                            good_cnt_d = GW'(1);
                        end
                    end
                end
            endcase
        end

        header_tx_d   = (state_d == S_ESTOP) ? HDR_ESTOP : HDR_DATA;
        fault_d       = (state_d != S_RUN);
        pkg_timeout_d = (wdog_d == TO_VAL);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FAULT;
            cmd_data_q    <= '0;
            cmd_update_q  <= 1'b0;
            header_tx_q   <= HDR_DATA;
            pkg_timeout_q <= 1'b1;
            fault_q       <= 1'b1;
            bad_cnt_q     <= '0;
            wdog_q        <= TO_VAL;
            good_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_data_q    <= cmd_data_d;
            cmd_update_q  <= cmd_update_d;
            header_tx_q   <= header_tx_d;
            pkg_timeout_q <= pkg_timeout_d;
            fault_q       <= fault_d;
            bad_cnt_q     <= bad_cnt_d;
            wdog_q        <= wdog_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign state         = state_q;
    assign cmd_data      = cmd_data_q;
    assign cmd_update    = cmd_update_q;
    assign header_tx     = header_tx_q;
    assign pkg_timeout   = pkg_timeout_q;
    assign fault         = fault_q;
    assign bad_frame_cnt = bad_cnt_q;

endmodule

// File: tb/tb_rio_frame_sequencer.sv
// Bench for rio_frame_sequencer: directed vector table, async-reset and saturation
// sequences, then random traffic against a cycle-age based reference model.
module tb_rio_frame_sequencer;

    localparam int          B     = 272;
    localparam int          PW    = B - 32;
    localparam int          TO    = 10;
    localparam int          ARM   = 3;
    localparam logic [31:0] MSGID = 32'h74697277;
    localparam logic [31:0] H_EST = 32'h65737470;
    localparam logic [31:0] H_DAT = 32'h64617461;
    localparam logic [31:0] JNT   = 32'h00001000;

    logic          sysclk, rst, frame_valid, estop_req;
    logic [B-1:0]  rx_data;
    logic [PW-1:0] cmd_data;
    logic          cmd_update, pkg_timeout, fault;
    logic [31:0]   header_tx;
    logic [1:0]    state;
    logic [15:0]   bad_frame_cnt;

    rio_frame_sequencer #(
        .BUFFER_SIZE(B), .MSGID(MSGID), .CLK_FREQ(1000), .TIMEOUT_MS(10), .ARM_FRAMES(ARM)
    ) dut (
        .sysclk(sysclk), .rst(rst), .frame_valid(frame_valid), .rx_data(rx_data),
        .estop_req(estop_req), .cmd_data(cmd_data), .cmd_update(cmd_update),
        .header_tx(header_tx), .pkg_timeout(pkg_timeout), .fault(fault),
        .state(state), .bad_frame_cnt(bad_frame_cnt)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    int total = 0;
    int errs  = 0;

    task automatic chk(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            if (errs <= 30) $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Wire order puts the header's low byte first.
    function automatic logic [B-1:0] mk_frame(input logic [31:0] h, input logic [PW-1:0] p);
        return {h[7:0], h[15:8], h[23:16], h[31:24], p};
    endfunction

    // Reference model: frame age since last good frame plus a good-frame streak.
    int            m_state, m_streak, m_age, m_bad;
    logic [PW-1:0] m_cmd;
    bit            m_upd;

    task automatic model_reset();
        m_state = 0; m_streak = 0; m_age = TO; m_bad = 0; m_cmd = '0; m_upd = 0;
    endtask

    task automatic model_step(input bit fv, input logic [31:0] h, input logic [PW-1:0] p,
                              input bit es);
        bit is_good, is_bad, timed_out;
        int new_age;
        is_good   = fv && (h == MSGID);
        is_bad    = fv && (h != MSGID);
        new_age   = is_good ? 0 : ((m_age + 1 > TO) ? TO : m_age + 1);
        timed_out = (new_age == TO);
        m_upd     = 0;
        if (is_bad && m_bad < 65535) m_bad++;
        if (es) begin
            m_state = 3; m_cmd = '0; m_streak = 0;
        end else if (m_state == 2) begin
            if (is_good) begin m_cmd = p; m_upd = 1; end
            else if (timed_out) begin m_state = 0; m_cmd = '0; end
        end else if (m_state == 1) begin
            if (is_good) begin
                m_streak++;
                if (m_streak >= ARM) begin m_state = 2; m_cmd = p; m_upd = 1; m_streak = 0; end
            end else if (is_bad || timed_out) begin
                m_state = 0; m_streak = 0;
            end
        end else if (is_good) begin
            m_streak = 1;
            if (m_streak >= ARM) begin m_state = 2; m_cmd = p; m_upd = 1; m_streak = 0; end
            else m_state = 1;
        end
        m_age = new_age;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " state"},   B'(state),         B'(m_state));
        chk({tag, " cmd"},     B'(cmd_data),      B'(m_cmd));
        chk({tag, " upd"},     B'(cmd_update),    B'(m_upd));
        chk({tag, " hdr_tx"},  B'(header_tx),     B'((m_state == 3) ? H_EST : H_DAT));
        chk({tag, " timeout"}, B'(pkg_timeout),   B'(m_age == TO));
        chk({tag, " fault"},   B'(fault),         B'(m_state != 2));
        chk({tag, " badcnt"},  B'(bad_frame_cnt), B'(m_bad));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " state"},   B'(state),         B'(0));
        chk({tag, " cmd"},     B'(cmd_data),      B'(0));
        chk({tag, " upd"},     B'(cmd_update),    B'(0));
        chk({tag, " hdr_tx"},  B'(header_tx),     B'(H_DAT));
        chk({tag, " timeout"}, B'(pkg_timeout),   B'(1));
        chk({tag, " fault"},   B'(fault),         B'(1));
        chk({tag, " badcnt"},  B'(bad_frame_cnt), B'(0));
    endtask

    // One clocked cycle with the model tracking the DUT.
    task automatic apply(input bit fv, input logic [31:0] h, input logic [PW-1:0] p, input bit es,
                         input string tag);
        frame_valid = fv;
        rx_data     = mk_frame(h, p);
        estop_req   = es;
        @(posedge sysclk);
        model_step(fv, h, p, es);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        int          kind;   // 0 idle, 1 good frame, 2 bad header
        bit          estop;
        int          st;
        bit          upd;
        bit          to;
        int          bad;
        logic [31:0] cmd;
    } vec_t;

    vec_t vt[$];

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] p;
        for (int k = 0; k < PW / 32; k++) p[k*32 +: 32] = $urandom;
        return p;
    endfunction

    initial begin
        logic [PW-1:0] jp;
        logic [31:0]   h;
        logic [PW-1:0] p;
        bit            fv, es;
        int            r, ph;

        jp = {208'h0, JNT};
        rst = 1'b1; frame_valid = 1'b0; estop_req = 1'b0; rx_data = '0;

        // Scenarios 1-5 as constant expectations.
        vt.push_back('{1, 0, 1, 0, 0, 0, 0});
        vt.push_back('{1, 0, 1, 0, 0, 0, 0});
        vt.push_back('{1, 0, 2, 1, 0, 0, JNT});
        for (int k = 1; k <= 5; k++) vt.push_back('{2, 0, 2, 0, 0, k, JNT});
        for (int k = 0; k < 4; k++)  vt.push_back('{0, 0, 2, 0, 0, 5, JNT});
        vt.push_back('{0, 0, 0, 0, 1, 5, 0});
        vt.push_back('{1, 0, 1, 0, 0, 5, 0});
        vt.push_back('{1, 0, 1, 0, 0, 5, 0});
        vt.push_back('{1, 0, 2, 1, 0, 5, JNT});
        vt.push_back('{1, 1, 3, 0, 0, 5, 0});
        vt.push_back('{1, 0, 1, 0, 0, 5, 0});
        vt.push_back('{1, 0, 1, 0, 0, 5, 0});
        vt.push_back('{2, 0, 0, 0, 0, 6, 0});
        vt.push_back('{1, 0, 1, 0, 0, 6, 0});
        vt.push_back('{1, 0, 1, 0, 0, 6, 0});
        vt.push_back('{1, 0, 2, 1, 0, 6, JNT});
        for (int k = 0; k < 9; k++)  vt.push_back('{0, 0, 2, 0, 0, 6, JNT});
        vt.push_back('{1, 0, 2, 1, 0, 6, JNT});
        for (int k = 0; k < 9; k++)  vt.push_back('{0, 0, 2, 0, 0, 6, JNT});
        vt.push_back('{0, 0, 0, 0, 1, 6, 0});

        repeat (2) @(posedge sysclk);
        #1;
        check_reset("reset");
        @(negedge sysclk);
        rst = 1'b0;

        foreach (vt[i]) begin
            frame_valid = (vt[i].kind != 0);
            rx_data     = mk_frame((vt[i].kind == 1) ? MSGID : 32'h0, jp);
            estop_req   = vt[i].estop;
            @(posedge sysclk);
            #1;
            chk($sformatf("vec%0d state", i),   B'(state),         B'(vt[i].st));
            chk($sformatf("vec%0d upd", i),     B'(cmd_update),    B'(vt[i].upd));
            chk($sformatf("vec%0d timeout", i), B'(pkg_timeout),   B'(vt[i].to));
            chk($sformatf("vec%0d badcnt", i),  B'(bad_frame_cnt), B'(vt[i].bad));
            chk($sformatf("vec%0d cmd", i),     B'(cmd_data),      B'({208'h0, vt[i].cmd}));
            chk($sformatf("vec%0d fault", i),   B'(fault),         B'(vt[i].st != 2));
            chk($sformatf("vec%0d hdr_tx", i),  B'(header_tx),     B'((vt[i].st == 3) ? H_EST : H_DAT));
        end
        frame_valid = 1'b0; estop_req = 1'b0;

        // Async reset mid-arming, held across an edge carrying a good frame.
        @(negedge sysclk); rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        @(negedge sysclk);
        apply(1, MSGID, jp, 0, "arm1");
        apply(1, MSGID, jp, 0, "arm2");
        #2 rst = 1'b1;
        #1 check_reset("async_arming");
        model_reset();
        frame_valid = 1'b1; rx_data = mk_frame(MSGID, jp);
        @(posedge sysclk);
        #1 check_reset("held_rst");
        @(negedge sysclk); rst = 1'b0; frame_valid = 1'b0;
        for (int k = 0; k < 3; k++) apply(1, MSGID, jp, 0, $sformatf("rearm%0d", k));
        #2 rst = 1'b1;
        #1 check_reset("async_run");
        model_reset();
        @(negedge sysclk); rst = 1'b0;

        // Random traffic against the model; phase 2 starves the link to force timeouts.
        es = 0;
        for (int i = 0; i < 3000; i++) begin
            ph = (i / 150) % 3;
            r  = $urandom_range(0, 99);
            fv = (ph == 2) ? (r < 5) : (r < 40);
            if (es) es = ($urandom_range(0, 99) >= 20);
            else    es = ($urandom_range(0, 99) < 2);
            r = $urandom_range(0, 99);
            if (r < 70)      h = MSGID;
            else if (r < 85) h = MSGID ^ (32'h1 << $urandom_range(0, 31));
            else             h = $urandom;
            p = rand_payload();
            apply(fv, h, p, es, $sformatf("rnd%0d", i));
        end
        frame_valid = 1'b0; estop_req = 1'b0;

        // Bad-frame counter saturation.
        @(negedge sysclk); rst = 1'b1; #1; rst = 1'b0;
        frame_valid = 1'b1; rx_data = mk_frame(32'h0, jp);
        repeat (65535) @(posedge sysclk);
        #1 chk("badcnt_full", B'(bad_frame_cnt), B'(16'hFFFF));
        @(posedge sysclk);
        #1 chk("badcnt_sat", B'(bad_frame_cnt), B'(16'hFFFF));
        frame_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, errs);
        $finish;
    end

endmodule
